// File: rtl/chirp_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chirp_burst_ctrl
// Purpose  : Chirp sample ROM sequencer. Plays a burst of cfg_count chirps,
//            each cfg_len+1 samples, with cfg_gap idle cycles between chirps.
//            ROM data is re-aligned with valid / sop / eop flags.
// Options  : CHIRP_UPDOWN_EN - odd-indexed chirps read the ROM descending.
// Revision : 1.0 - initial release
// ============================================================================
module chirp_burst_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int ROM_DW  = 16,
    parameter int DATA_W  = 14,
    parameter int ROM_LAT = 1,
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [GAP_W-1:0]  cfg_gap,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ROM_DW-1:0] rom_dout,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              chirp_sop,
    output logic              chirp_eop,
    output logic [CNT_W-1:0]  chirp_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_GAP   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_len_q;
    logic [CNT_W-1:0]  r_count_q;
    logic [GAP_W-1:0]  r_gap_q;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [1:0]        r_flush_cnt;

    // Address ordering for the current chirp and the start of the next one.
    logic [ADDR_W-1:0] w_first_addr;
    logic [ADDR_W-1:0] w_last_addr;
    logic [ADDR_W-1:0] w_step_addr;
    logic [ADDR_W-1:0] w_next_start;

`ifdef CHIRP_UPDOWN_EN
    logic w_desc;
    assign w_desc       = chirp_idx[0];
    assign w_first_addr = w_desc ? r_len_q : '0;
    assign w_last_addr  = w_desc ? '0 : r_len_q;
    assign w_step_addr  = w_desc ? (rom_addr - ADDR_W'(1)) : (rom_addr + ADDR_W'(1));
    // Next chirp has the opposite parity, hence the opposite direction.
    assign w_next_start = w_desc ? '0 : r_len_q;
`else
    assign w_first_addr = '0;
    assign w_last_addr  = r_len_q;
    assign w_step_addr  = rom_addr + ADDR_W'(1);
    assign w_next_start = '0;
`endif

    logic w_chirp_end;
    logic w_last_chirp;
    logic w_abort;
    logic [2:0] w_cur;
    logic [2:0] w_last_in;

    assign w_chirp_end  = (rom_addr == w_last_addr);
    assign w_last_chirp = (chirp_idx == (r_count_q - CNT_W'(1)));
    assign w_abort      = stop && ((r_state == ST_RUN) || (r_state == ST_GAP) ||
                                   (r_state == ST_FLUSH));
    // {valid, sop, eop} for the address being issued this cycle.
    assign w_cur        = {rom_en,
                           rom_en && (rom_addr == w_first_addr),
                           rom_en && w_chirp_end};

    // Burst sequencer: address generation, gaps, drain and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_len_q     <= '0;
            r_count_q   <= '0;
            r_gap_q     <= '0;
            r_gap_cnt   <= '0;
            r_flush_cnt <= '0;
            rom_en      <= 1'b0;
            rom_addr    <= '0;
            chirp_idx   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // stop has priority over a coincident start
                    if (start && !stop && (cfg_count != '0)) begin
                        r_len_q   <= cfg_len;
                        r_count_q <= cfg_count;
                        r_gap_q   <= cfg_gap;
                        r_state   <= ST_RUN;
                        rom_en    <= 1'b1;
                        rom_addr  <= '0;
                        chirp_idx <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        rom_en  <= 1'b0;
                        busy    <= 1'b0;
                    end else if (w_chirp_end) begin
                        if (w_last_chirp) begin
                            r_state     <= ST_FLUSH;
                            rom_en      <= 1'b0;
                            r_flush_cnt <= 2'd1;
                        end else if (r_gap_q == '0) begin
                            rom_addr  <= w_next_start;
                            chirp_idx <= chirp_idx + CNT_W'(1);
                        end else begin
                            r_state   <= ST_GAP;
                            rom_en    <= 1'b0;
                            r_gap_cnt <= GAP_W'(1);
                        end
                    end else begin
                        rom_addr <= w_step_addr;
                    end
                end
                ST_GAP: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (r_gap_cnt == r_gap_q) begin
                        r_state   <= ST_RUN;
                        rom_en    <= 1'b1;
                        rom_addr  <= w_next_start;
                        chirp_idx <= chirp_idx + CNT_W'(1);
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (r_flush_cnt == 2'(ROM_LAT)) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    rom_en  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Flag delay line; the last stage is captured together with ROM data.
    logic [2:0] r_dly [ROM_LAT];

    generate
        if (ROM_LAT == 1) begin : g_lat_one
            assign w_last_in = w_cur;
        end else begin : g_lat_multi
            assign w_last_in = r_dly[ROM_LAT-2];
        end
    endgenerate

    // Align valid/sop/eop with ROM read data; abort flushes in-flight samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROM_LAT; i++) r_dly[i] <= 3'b000;
            sample_out <= '0;
        end else if (w_abort) begin
            for (int i = 0; i < ROM_LAT; i++) r_dly[i] <= 3'b000;
            sample_out <= '0;
        end else begin
            r_dly[0] <= w_cur;
            for (int i = 1; i < ROM_LAT; i++) r_dly[i] <= r_dly[i-1];
            sample_out <= w_last_in[2] ? rom_dout[DATA_W-1:0] : '0;
        end
    end

    assign sample_valid = r_dly[ROM_LAT-1][2];
    assign chirp_sop    = r_dly[ROM_LAT-1][1];
    assign chirp_eop    = r_dly[ROM_LAT-1][0];

    // ROM MSBs above the sample width are intentionally dropped.
    generate
        if (ROM_DW > DATA_W) begin : g_rom_msbs
            logic w_unused_rom_msbs;
            assign w_unused_rom_msbs = ^rom_dout[ROM_DW-1:DATA_W];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_chirp_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chirp_burst_ctrl
// Purpose  : Scoreboard bench for chirp_burst_ctrl. Directed bursts push the
//            expected ROM reads, samples and done pulses (with cycle stamps)
//            into queues; monitors pop and compare as the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chirp_burst_ctrl;

    localparam int ADDR_W  = 9;
    localparam int ROM_DW  = 16;
    localparam int DATA_W  = 14;
    localparam int ROM_LAT = 1;
    localparam int CNT_W   = 8;
    localparam int GAP_W   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, stop;
    logic [ADDR_W-1:0] cfg_len;
    logic [CNT_W-1:0]  cfg_count;
    logic [GAP_W-1:0]  cfg_gap;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [ROM_DW-1:0] rom_dout;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid, chirp_sop, chirp_eop;
    logic [CNT_W-1:0]  chirp_idx;
    logic              busy, done;

    chirp_burst_ctrl #(
        .ADDR_W(ADDR_W), .ROM_DW(ROM_DW), .DATA_W(DATA_W),
        .ROM_LAT(ROM_LAT), .CNT_W(CNT_W), .GAP_W(GAP_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_len(cfg_len), .cfg_count(cfg_count), .cfg_gap(cfg_gap),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .sample_out(sample_out), .sample_valid(sample_valid),
        .chirp_sop(chirp_sop), .chirp_eop(chirp_eop),
        .chirp_idx(chirp_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: upper bits set so that dropping the MSBs is visible.
    function automatic logic [15:0] rom_word(input logic [ADDR_W-1:0] a);
        return 16'hC000 | (16'(a) * 16'd29 + 16'd7);
    endfunction

    // With ROM_LAT=1 the word for the issued address is captured on the next edge.
    assign rom_dout = rom_word(rom_addr);

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  idx;
    } rom_item_t;

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } smp_item_t;

    rom_item_t rom_q[$];
    smp_item_t smp_q[$];
    int        done_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: DUT output present, expected none (cycle %0d)", name, cyc);
    endtask

    // ROM-side monitor: address, chirp index and issue cycle.
    always @(negedge clk) begin
        if (rst_n && rom_en) begin
            if (rom_q.size() == 0) unexpected("rom_en");
            else begin
                rom_item_t it;
                it = rom_q.pop_front();
                chk("rom_cyc", cyc, it.cyc);
                chk("rom_addr", rom_addr, it.addr);
                chk("chirp_idx", chirp_idx, it.idx);
                chk("busy_run", busy, 1);
            end
        end
    end

    // Sample-side monitor: data, sop, eop and timing; quiet outputs otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sample_valid) begin
                if (smp_q.size() == 0) unexpected("sample_valid");
                else begin
                    smp_item_t it;
                    it = smp_q.pop_front();
                    chk("smp_cyc", cyc, it.cyc);
                    chk("sample_out", sample_out, it.data);
                    chk("chirp_sop", chirp_sop, it.sop);
                    chk("chirp_eop", chirp_eop, it.eop);
                end
            end else begin
                chk("idle_outputs", {sample_out, chirp_sop, chirp_eop}, 0);
            end
        end
    end

    // Done monitor: one pulse at the predicted cycle, with busy low.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (done_q.size() == 0) unexpected("done");
            else begin
                chk("done_cyc", cyc, done_q.pop_front());
                chk("busy_at_done", busy, 0);
            end
        end
    end

    // Expected traffic for one burst; abort_off<0 means the burst completes.
    task automatic build_expect(input int len, input int count, input int gap,
                                input int base, input int abort_off);
        int off = 0;
        for (int c = 0; c < count; c++) begin
            for (int s = 0; s <= len; s++) begin
                rom_item_t ri;
                smp_item_t si;
                logic [15:0] w;
                logic [ADDR_W-1:0] a;
                a = ADDR_W'(s);
`ifdef CHIRP_UPDOWN_EN
                if (c % 2 == 1) a = ADDR_W'(len - s);
`endif
                w = rom_word(a);
                ri.cyc = base + off; ri.addr = a; ri.idx = CNT_W'(c);
                si.cyc = base + off + ROM_LAT; si.data = w[DATA_W-1:0];
                si.sop = (s == 0); si.eop = (s == len);
                if (abort_off < 0 || off <= abort_off) rom_q.push_back(ri);
                if (abort_off < 0 || off + ROM_LAT <= abort_off) smp_q.push_back(si);
                off++;
            end
            if (c < count - 1) off += gap;
        end
        if (abort_off < 0) done_q.push_back(base + off + ROM_LAT);
    endtask

    task automatic run_burst(input int len, input int count, input int gap,
                             input int abort_off, output int base);
        @(negedge clk);
        cfg_len = ADDR_W'(len); cfg_count = CNT_W'(count); cfg_gap = GAP_W'(gap);
        start = 1'b1;
        base = cyc + 1;
        build_expect(len, count, gap, base, abort_off);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (!(rom_q.size() == 0 && smp_q.size() == 0 && done_q.size() == 0 && !busy)
               && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: left rom=%0d smp=%0d done=%0d busy=%0d, required all 0",
                     name, rom_q.size(), smp_q.size(), done_q.size(), busy);
            rom_q.delete(); smp_q.delete(); done_q.delete();
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_len = '0; cfg_count = '0; cfg_gap = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_sample_out", sample_out, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_sop", chirp_sop, 0);
        chk("rst_eop", chirp_eop, 0);
        chk("rst_chirp_idx", chirp_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Standard single chirp
        run_burst(450, 1, 0, -1, base);
        wait_idle("t1_std");

        // Three chirps with gaps; mid-burst start with new cfg must be ignored
        run_burst(7, 3, 4, -1, base);
        repeat (5) @(negedge clk);
        cfg_len = 9'd1; cfg_count = 8'd5; cfg_gap = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_mid_burst", busy, 1);
        wait_idle("t2_gap");

        // Back-to-back chirps, no bubble
        run_burst(3, 2, 0, -1, base);
        wait_idle("t3_b2b");

        // Single-sample chirps: sop and eop together
        run_burst(0, 3, 2, -1, base);
        wait_idle("t4_len0");

        // Abort at address 100 of chirp 1
        run_burst(450, 2, 0, 451 + 100, base);
        while (cyc < base + 551) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rom_en", rom_en, 0);
        wait_idle("t5_abort");

        // Full burst after abort
        run_burst(5, 2, 1, -1, base);
        wait_idle("t6_restart");

        // Ignored requests while idle
        @(negedge clk);
        cfg_len = 9'd3; cfg_count = 8'd0; cfg_gap = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("cnt0_busy", busy, 0);
        chk("cnt0_rom_en", rom_en, 0);
        cfg_count = 8'd2; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("startstop_busy", busy, 0);
        chk("startstop_rom_en", rom_en, 0);
        chk("idx_hold", chirp_idx, 1);
        wait_idle("t7_ignore");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
